ep2_frame_parser: RTL and testbench



---
 rtl/ep2_pkg.sv | 19 +
 rtl/ep2_frame_parser.sv | 116 +++++++++++
 tb/tb_ep2_frame_parser.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/ep2_pkg.sv
// Shared EP2 frame constants and parser state type, used by the frame parser,
// C&C decoder and TX FIFO writer.
package ep2_pkg;
    typedef enum logic [2:0] {
        SYNC0,
        SYNC1,
        SYNC2,
        CC,
        SAMPLE,
        DISCARD
    } ep2_state_t;

    localparam logic [7:0] SYNC_BYTE    = 8'h7F;
    localparam logic [8:0] CC_FIRST     = 9'd3;
    localparam logic [8:0] CC_LAST      = 9'd7;
    localparam logic [8:0] SAMPLE_FIRST = 9'd8;
    localparam int         SAMPLE_BYTES = 8;
    localparam int         FRAME_BYTES  = 512;
endpackage

// File: rtl/ep2_frame_parser.sv
// EP2 frame parser: checks 3-byte sync, extracts the C0..C4 block and assembles
// 8-byte samples into audio L/R and TX I/Q words, one byte per rx_clk.
module ep2_frame_parser
    import ep2_pkg::*;
#(
    parameter int FRAME_BYTES = 512,
    parameter int SAMPLES     = 63
) (
    input  logic        rx_clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_enable,
    output logic        cmd_valid,
    output logic        cmd_mox,
    output logic [6:0]  cmd_addr,
    output logic [31:0] cmd_data,
    output logic        tx_valid,
    output logic [15:0] tx_i,
    output logic [15:0] tx_q,
    output logic [15:0] audio_l,
    output logic [15:0] audio_r,
    output logic        frame_err,
    output logic [15:0] frame_cnt
);
    localparam logic [8:0] LAST_BYTE = 9'(FRAME_BYTES - 1);

    if (FRAME_BYTES != int'(SAMPLE_FIRST) + SAMPLE_BYTES * SAMPLES) begin : g_bad_cfg
        $error("ep2_frame_parser: FRAME_BYTES inconsistent with SAMPLES");
    end

    ep2_state_t  state;
    logic [8:0]  fcnt;
    logic        rx_en_d;
    logic [31:0] cc_sh;      // C0..C3; C4 is taken straight off the bus
    logic [55:0] smp_sh;     // first seven bytes of the current sample
    logic [63:0] smp_full;
    logic        en_fall;

    assign smp_full = {smp_sh, rx_data};
    assign en_fall  = rx_en_d && !rx_enable && !(state == SYNC0 && fcnt == 9'd0);

    always_ff @(posedge rx_clk or posedge rst) begin
        if (rst) begin
            state     <= SYNC0;
            fcnt      <= '0;
            rx_en_d   <= 1'b0;
            cc_sh     <= '0;
            smp_sh    <= '0;
            cmd_valid <= 1'b0;
            cmd_mox   <= 1'b0;
            cmd_addr  <= '0;
            cmd_data  <= '0;
            tx_valid  <= 1'b0;
            tx_i      <= '0;
            tx_q      <= '0;
            audio_l   <= '0;
            audio_r   <= '0;
            frame_err <= 1'b0;
            frame_cnt <= '0;
        end else begin
            cmd_valid <= 1'b0;
            tx_valid  <= 1'b0;
            frame_err <= 1'b0;
            rx_en_d   <= rx_enable;
            if (en_fall) begin
                // A gap always ends the packet; partial C&C/sample just never publish.
                state     <= SYNC0;
                fcnt      <= '0;
                frame_err <= (state != DISCARD);
            end else if (rx_enable) begin
                fcnt <= fcnt + 9'd1;
                unique case (state)
                    SYNC0, SYNC1, SYNC2: begin
                        if (rx_data == SYNC_BYTE) begin
                            state <= (state == SYNC0) ? SYNC1 :
                                     (state == SYNC1) ? SYNC2 : CC;
                        end else begin
                            state     <= DISCARD;
                            frame_err <= 1'b1;
                        end
                    end
                    CC: begin
                        if (fcnt == CC_LAST) begin
                            cmd_valid <= 1'b1;
                            cmd_mox   <= cc_sh[24];
                            cmd_addr  <= cc_sh[31:25];
                            cmd_data  <= {cc_sh[23:0], rx_data};
                            state     <= SAMPLE;
                        end else begin
                            cc_sh <= {cc_sh[23:0], rx_data};
                        end
                    end
                    SAMPLE: begin
                        smp_sh <= smp_full[55:0];
                        // Samples start at byte 8, so byte index [2:0]==7 closes one.
                        if (fcnt[2:0] == 3'd7) begin
                            tx_valid <= 1'b1;
                            audio_l  <= smp_full[63:48];
                            audio_r  <= smp_full[47:32];
                            tx_i     <= smp_full[31:16];
                            tx_q     <= smp_full[15:0];
                        end
                        if (fcnt == LAST_BYTE) begin
                            frame_cnt <= frame_cnt + 16'd1;
                            state     <= SYNC0;
                        end
                    end
                    DISCARD: begin
                        if (fcnt == LAST_BYTE) state <= SYNC0;
                    end
                    default: state <= SYNC0;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ep2_frame_parser.sv
// Directed bench for ep2_frame_parser: good/bad-sync/truncated packets, async
// reset mid-frame, frame counter wrap and back-to-back packets.
module tb_ep2_frame_parser;
    logic        rx_clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_enable;
    logic        cmd_valid, cmd_mox, tx_valid, frame_err;
    logic [6:0]  cmd_addr;
    logic [31:0] cmd_data;
    logic [15:0] tx_i, tx_q, audio_l, audio_r, frame_cnt;

    int n_chk = 0, n_err = 0;
    int n_cmd = 0, n_tx = 0, n_fe = 0, n_cbad = 0, n_tbad = 0;
    int b_cmd, b_tx, b_fe, b_cbad, b_tbad;
    logic [15:0] fc0;

    ep2_frame_parser dut (
        .rx_clk(rx_clk), .rst(rst), .rx_data(rx_data), .rx_enable(rx_enable),
        .cmd_valid(cmd_valid), .cmd_mox(cmd_mox), .cmd_addr(cmd_addr),
        .cmd_data(cmd_data), .tx_valid(tx_valid), .tx_i(tx_i), .tx_q(tx_q),
        .audio_l(audio_l), .audio_r(audio_r), .frame_err(frame_err),
        .frame_cnt(frame_cnt)
    );

    always #5 rx_clk = ~rx_clk;

    // Pulse counters; every payload in this bench carries the same C&C and sample.
    always @(negedge rx_clk) begin
        if (!rst) begin
            if (cmd_valid) begin
                n_cmd++;
                if (cmd_mox !== 1'b1 || cmd_addr !== 7'd0 || cmd_data !== 32'h11223344) n_cbad++;
            end
            if (tx_valid) begin
                n_tx++;
                if (tx_i !== 16'h1234 || tx_q !== 16'hFEDC ||
                    audio_l !== 16'h0001 || audio_r !== 16'h8000) n_tbad++;
            end
            if (frame_err) n_fe++;
        end
    end

    function automatic logic [7:0] frame_byte(input int idx);
        logic [7:0] smp [8];
        smp = '{8'h00, 8'h01, 8'h80, 8'h00, 8'h12, 8'h34, 8'hFE, 8'hDC};
        case (idx)
            0, 1, 2: return 8'h7F;
            3:       return 8'h01;
            4:       return 8'h11;
            5:       return 8'h22;
            6:       return 8'h33;
            7:       return 8'h44;
            default: return smp[(idx - 8) % 8];
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge rx_clk); #1;
        rx_enable = 1'b1;
        rx_data   = b;
    endtask

    task automatic idle(input int n);
        @(posedge rx_clk); #1;
        rx_enable = 1'b0;
        rx_data   = 8'h00;
        repeat (n) @(posedge rx_clk);
        #1;
    endtask

    task automatic send_packet(input int nbytes, input int bad_idx, input logic [7:0] bad_val);
        for (int i = 0; i < nbytes; i++)
            send_byte((i == bad_idx) ? bad_val : frame_byte(i % 512));
    endtask

    task automatic snap();
        b_cmd = n_cmd; b_tx = n_tx; b_fe = n_fe; b_cbad = n_cbad; b_tbad = n_tbad;
        fc0 = frame_cnt;
    endtask

    task automatic chk_counts(input string tag, input int ecmd, input int etx, input int efe);
        chk({tag, ".cmd_valid_count"}, n_cmd - b_cmd, ecmd);
        chk({tag, ".tx_valid_count"}, n_tx - b_tx, etx);
        chk({tag, ".frame_err_count"}, n_fe - b_fe, efe);
        chk({tag, ".cmd_payload_bad"}, n_cbad - b_cbad, 0);
        chk({tag, ".tx_payload_bad"}, n_tbad - b_tbad, 0);
    endtask

    initial begin
        rst = 1'b1; rx_enable = 1'b0; rx_data = 8'h00;
        repeat (3) @(posedge rx_clk);
        #1;
        chk("reset.frame_cnt", frame_cnt, 0);
        chk("reset.cmd_data", cmd_data, 0);
        chk("reset.tx_i", tx_i, 0);
        chk("reset.pulses", {cmd_valid, tx_valid, frame_err}, 0);
        rst = 1'b0;
        idle(2);

        // Good packet
        snap();
        send_packet(1024, -1, 8'h00);
        idle(3);
        chk_counts("good", 2, 126, 0);
        chk("good.frame_cnt", frame_cnt, 2);
        chk("good.cmd_mox", cmd_mox, 1);
        chk("good.cmd_addr", cmd_addr, 0);
        chk("good.cmd_data", cmd_data, 32'h11223344);
        chk("good.tx_i", tx_i, 16'h1234);
        chk("good.tx_q", tx_q, 16'hFEDC);
        chk("good.audio_l", audio_l, 16'h0001);
        chk("good.audio_r", audio_r, 16'h8000);

        // Bad sync in frame 0
        snap();
        send_packet(1024, 1, 8'h7E);
        idle(3);
        chk_counts("badsync", 1, 63, 1);
        chk("badsync.frame_cnt", frame_cnt, 3);

        // Truncation after 300 bytes
        snap();
        send_packet(300, -1, 8'h00);
        @(posedge rx_clk); #1;
        rx_enable = 1'b0;
        @(negedge rx_clk);
        @(negedge rx_clk);
        chk("trunc.frame_err_timing", frame_err, 1);
        idle(3);
        chk_counts("trunc", 1, 36, 1);
        chk("trunc.frame_cnt", frame_cnt, 3);
        snap();
        send_packet(1024, -1, 8'h00);
        idle(3);
        chk_counts("after_trunc", 2, 126, 0);
        chk("after_trunc.frame_cnt", frame_cnt, 5);

        // Async reset at byte 5
        send_packet(5, -1, 8'h00);
        send_byte(frame_byte(5));
        #2 rst = 1'b1;
        #1;
        chk("async_rst.frame_cnt", frame_cnt, 0);
        chk("async_rst.cmd_data", cmd_data, 0);
        chk("async_rst.audio_r", audio_r, 0);
        chk("async_rst.tx_q", tx_q, 0);
        rx_enable = 1'b0;
        repeat (2) @(posedge rx_clk);
        #1 rst = 1'b0;
        idle(2);
        snap();
        send_packet(1024, -1, 8'h00);
        idle(3);
        chk_counts("post_rst", 2, 126, 0);
        chk("post_rst.frame_cnt", frame_cnt, 2);

        // Back-to-back packets, one idle cycle between
        snap();
        send_packet(1024, -1, 8'h00);
        @(posedge rx_clk); #1;
        rx_enable = 1'b0;
        send_packet(1024, -1, 8'h00);
        idle(3);
        chk_counts("b2b", 4, 252, 0);
        chk("b2b.frame_cnt", frame_cnt, 6);

        // frame_cnt wrap
        @(negedge rx_clk);
        force dut.frame_cnt = 16'hFFFF;
        @(posedge rx_clk); #1;
        release dut.frame_cnt;
        chk("wrap.preload", frame_cnt, 16'hFFFF);
        snap();
        send_packet(512, -1, 8'h00);
        idle(3);
        chk_counts("wrap", 1, 63, 0);
        chk("wrap.frame_cnt", frame_cnt, 16'h0000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
